// File: rtl/cache_ctrl_pkg.sv
// Shared types and helpers for the cache miss controller.
// State encoding, default geometry and address field extraction.
package cache_ctrl_pkg;

    localparam int DEF_OFFSET_WIDTH = 3;
    localparam int DEF_INDEX_WIDTH  = 6;
    localparam int DEF_TAG_WIDTH    = 30 - DEF_OFFSET_WIDTH - DEF_INDEX_WIDTH;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COMPARE = 3'd1,
        VICTIM  = 3'd2,
        WB      = 3'd3,
        REFILL  = 3'd4,
        INSTALL = 3'd5
    } state_t;

    // Word within the block: addr[ow+1:2], returned right-aligned.
    function automatic logic [31:0] addr_word_sel(input logic [31:0] addr, input int ow);
        return (addr >> 2) & ((32'd1 << ow) - 32'd1);
    endfunction

    // Set index: the iw bits directly above the word select.
    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int ow, input int iw);
        return (addr >> (ow + 2)) & ((32'd1 << iw) - 32'd1);
    endfunction

    // Tag: the top tw bits of the address.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int tw);
        return addr >> (32 - tw);
    endfunction

endpackage

// File: rtl/cache_perf_cnt.sv
// Three saturating 32-bit event counters (hits, misses, write-backs).
// Only instantiated when CACHE_MISS_CTRL_PERF_EN is defined.
module cache_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_hit,
    input  logic        inc_miss,
    input  logic        inc_wb,
    output logic [31:0] hits,
    output logic [31:0] misses,
    output logic [31:0] wbs
);

    // Count each event, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hits   <= '0;
            misses <= '0;
            wbs    <= '0;
        end else begin
            if (inc_hit  && hits   != 32'hFFFF_FFFF) hits   <= hits + 32'd1;
            if (inc_miss && misses != 32'hFFFF_FFFF) misses <= misses + 32'd1;
            if (inc_wb   && wbs    != 32'hFFFF_FFFF) wbs    <= wbs + 32'd1;
        end
    end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss-handling control FSM in front of a 2-way cache array.
// Latches one CPU request, runs the tag compare, and on a miss performs
// victim read, optional write-back, refill, install and compare replay.
// Optional macro CACHE_MISS_CTRL_PERF_EN adds perf_hits/perf_misses/perf_wbs.
// state_dbg exposes the FSM state for checkers.
// Handshake: mem_req/mem_we/mem_addr/mem_wdata hold steady from the first
// request cycle through the cycle mem_ack=1; mem_req falls on the next edge.
// mem_ack seen while mem_req=0 has no effect. cpu_req is taken only while
// cpu_ready=1; cpu_done is a single-cycle completion pulse.
module cache_miss_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
    parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
    parameter int TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH,
    parameter int BLK_W        = 32 << OFFSET_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [31:0]             cpu_addr,
    input  logic [3:0]              cpu_byte_en,
    input  logic [31:0]             cpu_wdata,
    output logic                    cpu_ready,
    output logic                    cpu_done,
    output logic [31:0]             cpu_rdata,
    output logic                    c_enable,
    output logic                    c_cmp,
    output logic                    c_write,
    output logic                    c_valid_in,
    output logic [3:0]              c_byte_w_en,
    output logic [TAG_WIDTH-1:0]    c_tag,
    output logic [INDEX_WIDTH-1:0]  c_index,
    output logic [OFFSET_WIDTH-1:0] c_word_sel,
    output logic [31:0]             c_data_in,
    output logic [BLK_W-1:0]        c_block_in,
    input  logic                    c_hit,
    input  logic                    c_dirty,
    input  logic                    c_valid,
    input  logic [TAG_WIDTH-1:0]    c_tag_out,
    input  logic [31:0]             c_data_out,
    input  logic [BLK_W-1:0]        c_data_wb,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [31:0]             mem_addr,
    output logic [BLK_W-1:0]        mem_wdata,
    input  logic [BLK_W-1:0]        mem_rdata,
    input  logic                    mem_ack,
`ifdef CACHE_MISS_CTRL_PERF_EN
    output logic [31:0]             perf_hits,
    output logic [31:0]             perf_misses,
    output logic [31:0]             perf_wbs,
`endif
    output logic [2:0]              state_dbg
);

    state_t                 state, state_nx;
    logic [31:2]            req_addr;
    logic                   req_we;
    logic [3:0]             req_be;
    logic [31:0]            req_wdata;
    logic [TAG_WIDTH-1:0]   vic_tag;
    logic [BLK_W-1:0]       vic_blk;
    logic                   vic_valid;
    logic                   vic_dirty;
    logic [BLK_W-1:0]       fill_blk;
    logic                   replay;

    // Array address fields always come from the request latch.
    assign c_tag      = TAG_WIDTH'(addr_tag({req_addr, 2'b00}, TAG_WIDTH));
    assign c_index    = INDEX_WIDTH'(addr_index({req_addr, 2'b00}, OFFSET_WIDTH, INDEX_WIDTH));
    assign c_word_sel = OFFSET_WIDTH'(addr_word_sel({req_addr, 2'b00}, OFFSET_WIDTH));
    assign c_data_in  = req_wdata;
    assign c_block_in = fill_blk;
    assign mem_wdata  = vic_blk;
    assign state_dbg  = state;

    // State register plus request, victim and refill latches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_be    <= '0;
            req_wdata <= '0;
            vic_tag   <= '0;
            vic_blk   <= '0;
            vic_valid <= 1'b0;
            vic_dirty <= 1'b0;
            fill_blk  <= '0;
            replay    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_addr  <= cpu_addr[31:2];
                        req_we    <= cpu_we;
                        req_be    <= cpu_byte_en;
                        req_wdata <= cpu_wdata;
                    end
                end
                COMPARE: begin
                    if (c_hit) replay <= 1'b0;
                end
                VICTIM: begin
                    vic_tag   <= c_tag_out;
                    vic_blk   <= c_data_wb;
                    vic_valid <= c_valid;
                    vic_dirty <= c_dirty;
                end
                REFILL: begin
                    if (mem_ack) fill_blk <= mem_rdata;
                end
                INSTALL: replay <= 1'b1;
                default: ;
            endcase
        end
    end

    // Next state and all state-decoded control outputs.
    always_comb begin
        state_nx    = state;
        cpu_ready   = 1'b0;
        cpu_done    = 1'b0;
        cpu_rdata   = '0;
        c_enable    = 1'b0;
        c_cmp       = 1'b0;
        c_write     = 1'b0;
        c_valid_in  = 1'b0;
        c_byte_w_en = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        case (state)
            IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req) state_nx = COMPARE;
            end
            COMPARE: begin
                c_enable    = 1'b1;
                c_cmp       = 1'b1;
                c_write     = req_we;
                c_byte_w_en = req_we ? req_be : 4'h0;
                if (c_hit) begin
                    cpu_done  = 1'b1;
                    cpu_rdata = c_data_out;
                    state_nx  = IDLE;
                end else begin
                    state_nx = VICTIM;
                end
            end
            VICTIM: begin
                c_enable = 1'b1;
                state_nx = (c_valid && c_dirty) ? WB : REFILL;
            end
            WB: begin
                // Only reachable with a valid dirty victim latched.
                mem_req  = vic_valid & vic_dirty;
                mem_we   = 1'b1;
                mem_addr = {vic_tag, c_index, (OFFSET_WIDTH + 2)'(0)};
                if (mem_ack) state_nx = REFILL;
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {c_tag, c_index, (OFFSET_WIDTH + 2)'(0)};
                if (mem_ack) state_nx = INSTALL;
            end
            INSTALL: begin
                c_enable    = 1'b1;
                c_write     = 1'b1;
                c_valid_in  = 1'b1;
                c_byte_w_en = 4'hF;
                state_nx    = COMPARE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef CACHE_MISS_CTRL_PERF_EN
    logic inc_hit, inc_miss, inc_wb;

    // Replayed compares after an install are not counted as hits.
    assign inc_hit  = (state == COMPARE) && c_hit && !replay;
    assign inc_miss = (state == COMPARE) && !c_hit;
    assign inc_wb   = (state == WB) && mem_ack;

    cache_perf_cnt u_perf (
        .clk      (clk),
        .rst      (rst),
        .inc_hit  (inc_hit),
        .inc_miss (inc_miss),
        .inc_wb   (inc_wb),
        .hits     (perf_hits),
        .misses   (perf_misses),
        .wbs      (perf_wbs)
    );
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl. The bench plays the array and memory
// by hand, driving status inputs cycle by cycle and checking the controls.
module tb_cache_miss_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0]  cpu_addr = '0;
    logic [3:0]   cpu_byte_en = '0;
    logic [31:0]  cpu_wdata = '0;
    logic         cpu_ready, cpu_done;
    logic [31:0]  cpu_rdata;
    logic         c_enable, c_cmp, c_write, c_valid_in;
    logic [3:0]   c_byte_w_en;
    logic [20:0]  c_tag;
    logic [5:0]   c_index;
    logic [2:0]   c_word_sel;
    logic [31:0]  c_data_in;
    logic [255:0] c_block_in;
    logic         c_hit = 1'b0, c_dirty = 1'b0, c_valid = 1'b0;
    logic [20:0]  c_tag_out = '0;
    logic [31:0]  c_data_out = '0;
    logic [255:0] c_data_wb = '0;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata = '0;
    logic         mem_ack = 1'b0;
    logic [2:0]   state_dbg;
`ifdef CACHE_MISS_CTRL_PERF_EN
    logic [31:0]  perf_hits, perf_misses, perf_wbs;
`endif

    int total = 0;
    int bad   = 0;

    cache_miss_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_byte_en(cpu_byte_en), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .c_enable(c_enable), .c_cmp(c_cmp), .c_write(c_write),
        .c_valid_in(c_valid_in), .c_byte_w_en(c_byte_w_en),
        .c_tag(c_tag), .c_index(c_index), .c_word_sel(c_word_sel),
        .c_data_in(c_data_in), .c_block_in(c_block_in),
        .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid),
        .c_tag_out(c_tag_out), .c_data_out(c_data_out), .c_data_wb(c_data_wb),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
`ifdef CACHE_MISS_CTRL_PERF_EN
        .perf_hits(perf_hits), .perf_misses(perf_misses), .perf_wbs(perf_wbs),
`endif
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step;
        step;
        #1;
        total++;
        if (state_dbg !== 3'd0 || cpu_ready !== 1'b1 || cpu_done !== 1'b0 || cpu_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_cpu state=%0d ready=%0b done=%0b rdata=%h exp 0/1/0/0", state_dbg, cpu_ready, cpu_done, cpu_rdata);
        end
        total++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || c_enable !== 1'b0 ||
            c_write !== 1'b0 || c_cmp !== 1'b0 || c_tag !== 21'd0 || c_block_in !== 256'd0) begin
            bad++;
            $display("FAIL reset_ctrl mem_req=%0b mem_addr=%h c_en=%0b c_tag=%h exp zeros", mem_req, mem_addr, c_enable, c_tag);
        end
        rst = 1'b1;
        step;
    endtask

    task automatic test_cold_miss;
        logic [255:0] blk;
        blk = '0;
        blk[31:0]  = 32'hDEADBEEF;
        blk[63:32] = 32'h1111_1111;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1040; #1;
        step;                                   // COMPARE
        cpu_req = 1'b0; c_hit = 1'b0; #1;
        total++;
        if (state_dbg !== 3'd1 || c_enable !== 1'b1 || c_cmp !== 1'b1 || c_write !== 1'b0 ||
            c_tag !== 21'd2 || c_index !== 6'd2 || c_word_sel !== 3'd0 || cpu_done !== 1'b0) begin
            bad++;
            $display("FAIL cold_compare state=%0d en=%0b cmp=%0b wr=%0b tag=%0d idx=%0d ws=%0d exp 1/1/1/0/2/2/0", state_dbg, c_enable, c_cmp, c_write, c_tag, c_index, c_word_sel);
        end
        step;                                   // VICTIM, clean way
        c_valid = 1'b0; c_dirty = 1'b0; c_tag_out = 21'd0; #1;
        total++;
        if (state_dbg !== 3'd2 || c_enable !== 1'b1 || c_cmp !== 1'b0 || c_write !== 1'b0 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL cold_victim state=%0d en=%0b cmp=%0b wr=%0b mem_req=%0b exp 2/1/0/0/0", state_dbg, c_enable, c_cmp, c_write, mem_req);
        end
        step;                                   // REFILL, acked at once
        mem_ack = 1'b1; mem_rdata = blk; #1;
        total++;
        if (state_dbg !== 3'd4 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0000_1040) begin
            bad++;
            $display("FAIL cold_refill state=%0d req=%0b we=%0b addr=%h exp 4/1/0/00001040", state_dbg, mem_req, mem_we, mem_addr);
        end
        step;                                   // INSTALL
        mem_ack = 1'b0; mem_rdata = '0; #1;
        total++;
        if (state_dbg !== 3'd5 || c_enable !== 1'b1 || c_cmp !== 1'b0 || c_write !== 1'b1 || c_valid_in !== 1'b1 ||
            c_byte_w_en !== 4'hF || c_block_in !== blk || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL cold_install state=%0d wr=%0b vin=%0b be=%h mem_req=%0b blk_ok=%0b exp 5/1/1/f/0/1", state_dbg, c_write, c_valid_in, c_byte_w_en, mem_req, c_block_in === blk);
        end
        step;                                   // replayed COMPARE hits
        c_hit = 1'b1; c_data_out = 32'hDEADBEEF; #1;
        total++;
        if (state_dbg !== 3'd1 || cpu_done !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL cold_replay state=%0d done=%0b rdata=%h exp 1/1/deadbeef", state_dbg, cpu_done, cpu_rdata);
        end
        step;
        c_hit = 1'b0; c_data_out = '0; #1;
        total++;
        if (state_dbg !== 3'd0 || cpu_done !== 1'b0 || cpu_ready !== 1'b1) begin
            bad++;
            $display("FAIL cold_back_idle state=%0d done=%0b ready=%0b exp 0/0/1", state_dbg, cpu_done, cpu_ready);
        end
    endtask

    task automatic test_back_to_back;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1040; #1;
        step;                                   // COMPARE, hit, req still high
        c_hit = 1'b1; c_data_out = 32'hDEADBEEF; #1;
        total++;
        if (cpu_done !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || mem_req !== 1'b0 || cpu_ready !== 1'b0) begin
            bad++;
            $display("FAIL hit_latency done=%0b rdata=%h mem_req=%0b ready=%0b exp 1/deadbeef/0/0", cpu_done, cpu_rdata, mem_req, cpu_ready);
        end
        step;                                   // request in done cycle not taken
        c_hit = 1'b0; c_data_out = '0; #1;
        total++;
        if (state_dbg !== 3'd0 || cpu_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_not_taken state=%0d ready=%0b exp 0/1", state_dbg, cpu_ready);
        end
        step;                                   // taken now
        cpu_req = 1'b0; c_hit = 1'b1; c_data_out = 32'h1111_1111; #1;
        total++;
        if (state_dbg !== 3'd1 || cpu_done !== 1'b1 || cpu_rdata !== 32'h1111_1111) begin
            bad++;
            $display("FAIL b2b_second state=%0d done=%0b rdata=%h exp 1/1/11111111", state_dbg, cpu_done, cpu_rdata);
        end
        step;
        c_hit = 1'b0; c_data_out = '0; #1;
    endtask

    task automatic test_store_hit;
        logic [31:0] merged;
        merged = {16'h1111, 16'h5678};          // old word 0x11111111, low half replaced
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_1044;
        cpu_byte_en = 4'b0011; cpu_wdata = 32'h1234_5678; #1;
        step;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte_en = '0; cpu_wdata = '0; c_hit = 1'b1; #1;
        total++;
        if (c_write !== 1'b1 || c_byte_w_en !== 4'b0011 || c_word_sel !== 3'd1 ||
            c_data_in !== 32'h1234_5678 || cpu_done !== 1'b1 || c_cmp !== 1'b1) begin
            bad++;
            $display("FAIL store_hit wr=%0b be=%b ws=%0d din=%h done=%0b exp 1/0011/1/12345678/1", c_write, c_byte_w_en, c_word_sel, c_data_in, cpu_done);
        end
        step;
        c_hit = 1'b0; #1;
        cpu_req = 1'b1; cpu_addr = 32'h0000_1044; #1;
        step;
        cpu_req = 1'b0; c_hit = 1'b1; c_data_out = merged; #1;
        total++;
        if (c_write !== 1'b0 || c_byte_w_en !== 4'h0 || cpu_done !== 1'b1 || cpu_rdata !== 32'h1111_5678) begin
            bad++;
            $display("FAIL load_merged wr=%0b be=%h done=%0b rdata=%h exp 0/0/1/11115678", c_write, c_byte_w_en, cpu_done, cpu_rdata);
        end
        step;
        c_hit = 1'b0; c_data_out = '0; #1;
    endtask

    task automatic test_dirty_miss;
        logic [255:0] vblk, fblk;
        vblk = {8{32'hA5A5_0003}};
        fblk = {8{32'h4444_0004}};
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_2040; #1;
        step;                                   // COMPARE miss
        cpu_req = 1'b0; #1;
        step;                                   // VICTIM: valid dirty way tag 3
        c_valid = 1'b1; c_dirty = 1'b1; c_tag_out = 21'd3; c_data_wb = vblk; #1;
        step;                                   // WB, ack held off two cycles
        c_valid = 1'b0; c_dirty = 1'b0; c_tag_out = '0; c_data_wb = '0; #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (state_dbg !== 3'd3 || mem_req !== 1'b1 || mem_we !== 1'b1 ||
                mem_addr !== 32'h0000_1840 || mem_wdata !== vblk) begin
                bad++;
                $display("FAIL dirty_wb cyc=%0d state=%0d req=%0b we=%0b addr=%h wdata_ok=%0b exp 3/1/1/00001840/1", i, state_dbg, mem_req, mem_we, mem_addr, mem_wdata === vblk);
            end
            step;
        end
        mem_ack = 1'b1; #1;
        step;                                   // REFILL of the requested block
        mem_ack = 1'b0; #1;
        total++;
        if (state_dbg !== 3'd4 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0000_2040) begin
            bad++;
            $display("FAIL dirty_refill state=%0d req=%0b we=%0b addr=%h exp 4/1/0/00002040", state_dbg, mem_req, mem_we, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = fblk; #1;
        step;                                   // INSTALL
        mem_ack = 1'b0; mem_rdata = '0; #1;
        total++;
        if (state_dbg !== 3'd5 || c_block_in !== fblk || c_tag !== 21'd4) begin
            bad++;
            $display("FAIL dirty_install state=%0d tag=%0d blk_ok=%0b exp 5/4/1", state_dbg, c_tag, c_block_in === fblk);
        end
        step;
        c_hit = 1'b1; c_data_out = 32'h4444_0004; #1;
        total++;
        if (cpu_done !== 1'b1 || cpu_rdata !== 32'h4444_0004) begin
            bad++;
            $display("FAIL dirty_done done=%0b rdata=%h exp 1/44440004", cpu_done, cpu_rdata);
        end
        step;
        c_hit = 1'b0; c_data_out = '0; #1;
    endtask

    task automatic test_refill_stall;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_3040; #1;
        step;                                   // COMPARE miss
        cpu_req = 1'b0; #1;
        step;                                   // VICTIM clean
        step;                                   // REFILL, 7 cycles without ack
        for (int i = 0; i < 7; i++) begin
            cpu_req = i[0]; cpu_addr = 32'h0000_5000; #1;
            total++;
            if (state_dbg !== 3'd4 || mem_req !== 1'b1 || mem_addr !== 32'h0000_3040 || cpu_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall cyc=%0d state=%0d req=%0b addr=%h ready=%0b exp 4/1/00003040/0", i, state_dbg, mem_req, mem_addr, cpu_ready);
            end
            step;
        end
        cpu_req = 1'b0; mem_ack = 1'b1; mem_rdata = {8{32'h6666_0006}}; #1;
        step;                                   // INSTALL, request latch untouched
        mem_ack = 1'b0; mem_rdata = '0; #1;
        total++;
        if (state_dbg !== 3'd5 || c_tag !== 21'd6 || c_index !== 6'd2 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL stall_install state=%0d tag=%0d idx=%0d mem_req=%0b exp 5/6/2/0", state_dbg, c_tag, c_index, mem_req);
        end
        step;
        c_hit = 1'b1; c_data_out = 32'h6666_0006; #1;
        step;
        c_hit = 1'b0; c_data_out = '0; #1;
    endtask

    task automatic test_ack_ignored;
        mem_ack = 1'b1; #1;
        step;
        mem_ack = 1'b0; #1;
        total++;
        if (state_dbg !== 3'd0 || mem_req !== 1'b0 || cpu_ready !== 1'b1) begin
            bad++;
            $display("FAIL stray_ack state=%0d mem_req=%0b ready=%0b exp 0/0/1", state_dbg, mem_req, cpu_ready);
        end
    endtask

    task automatic test_reset_mid_wb;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_2040; #1;
        step;
        cpu_req = 1'b0; #1;
        step;                                   // VICTIM dirty, tag 4
        c_valid = 1'b1; c_dirty = 1'b1; c_tag_out = 21'd4; c_data_wb = {8{32'hBBBB_0004}}; #1;
        step;                                   // WB
        c_valid = 1'b0; c_dirty = 1'b0; c_tag_out = '0; c_data_wb = '0; #1;
        total++;
        if (state_dbg !== 3'd3 || mem_req !== 1'b1 || mem_addr !== 32'h0000_2040) begin
            bad++;
            $display("FAIL rst_pre_wb state=%0d req=%0b addr=%h exp 3/1/00002040", state_dbg, mem_req, mem_addr);
        end
`ifdef CACHE_MISS_CTRL_PERF_EN
        total++;
        if (perf_hits !== 32'd4 || perf_misses !== 32'd4 || perf_wbs !== 32'd1) begin
            bad++;
            $display("FAIL perf_counts hits=%0d misses=%0d wbs=%0d exp 4/4/1", perf_hits, perf_misses, perf_wbs);
        end
`endif
        rst = 1'b0; #1;                         // asynchronous, mid-cycle
        total++;
        if (mem_req !== 1'b0 || cpu_ready !== 1'b1 || state_dbg !== 3'd0 || cpu_done !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_wb req=%0b ready=%0b state=%0d done=%0b exp 0/1/0/0", mem_req, cpu_ready, state_dbg, cpu_done);
        end
`ifdef CACHE_MISS_CTRL_PERF_EN
        total++;
        if (perf_hits !== 32'd0 || perf_misses !== 32'd0 || perf_wbs !== 32'd0) begin
            bad++;
            $display("FAIL perf_cleared hits=%0d misses=%0d wbs=%0d exp 0/0/0", perf_hits, perf_misses, perf_wbs);
        end
`endif
        step;
        rst = 1'b1; #1;
        step;
        total++;
        if (c_tag !== 21'd0 || c_index !== 6'd0 || state_dbg !== 3'd0 || cpu_done !== 1'b0 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL rst_discard tag=%0d idx=%0d state=%0d done=%0b req=%0b exp 0/0/0/0/0", c_tag, c_index, state_dbg, cpu_done, mem_req);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_store_hit();
        test_dirty_miss();
        test_refill_stall();
        test_ack_ignored();
        test_reset_mid_wb();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
